// File: rtl/spi_slave_core.sv
// Oversampled SPI slave endpoint: synchronises sclk/mosi/ss into clk, supports all CPOL/CPHA modes.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB-first (default MSB-first).
module spi_slave_core #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             abort,
    output logic             tx_underrun,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, XFER = 2'd2} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       shifter, rx_shift, buf_q, pend_word;
    logic                   first_shift, reload_pend, word_done;

    logic sclk_s, mosi_s, ss_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall, active;
    logic sample_edge, shift_edge, final_sample, reload, transfer, load_acc;
    logic [WIDTH-1:0] next_word, rx_next, tx_shifted;
    logic tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Gating on the delayed ss lets a final sample edge coinciding with ss rise still count.
    assign active       = (state_q == XFER) & ~ss_d;
    assign sample_edge  = active & ((cpol == cpha) ? sclk_rise : sclk_fall);
    assign shift_edge   = active & ((cpol == cpha) ? sclk_fall : sclk_rise);
    assign final_sample = sample_edge & (bit_cnt == CW'(WIDTH - 1));
    assign reload       = word_done & (state_q == XFER);
    assign transfer     = (state_q == LOAD) | reload;
    assign load_acc     = tx_load & (tx_ready | transfer);
    assign next_word    = tx_ready ? '0 : buf_q;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_s, rx_shift[WIDTH-1:1]};
    assign tx_shifted = {1'b0, shifter[WIDTH-1:1]};
    assign tx_bit     = shifter[0];
`else
    assign rx_next    = {rx_shift[WIDTH-2:0], mosi_s};
    assign tx_shifted = {shifter[WIDTH-2:0], 1'b0};
    assign tx_bit     = shifter[WIDTH-1];
`endif

    assign miso      = (state_q != IDLE) & tx_bit;
    assign busy      = ~ss_s;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD:    state_d = ss_rise ? IDLE : XFER;
            XFER:    if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready    <= 1'b1;
            buf_q       <= '0;
            shifter     <= '0;
            pend_word   <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            abort       <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            first_shift <= 1'b0;
            reload_pend <= 1'b0;
            word_done   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            abort       <= 1'b0;
            tx_underrun <= transfer & tx_ready;
            word_done   <= final_sample;

            // A load in the transfer cycle refills the buffer after the old word is taken.
            if (load_acc) begin
                buf_q    <= tx_data;
                tx_ready <= 1'b0;
            end else if (transfer) begin
                tx_ready <= 1'b1;
            end

            if (state_q == LOAD) begin
                shifter     <= next_word;
                bit_cnt     <= '0;
                first_shift <= 1'b1;
                reload_pend <= 1'b0;
            end

            if (reload) begin
                pend_word   <= next_word;
                reload_pend <= 1'b1;
            end

            if (word_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            if (sample_edge) begin
                rx_shift <= rx_next;
                bit_cnt  <= final_sample ? '0 : bit_cnt + CW'(1);
            end

            // The pending reload replaces the shift and also serves as the first shift of cpha=1.
            if (shift_edge) begin
                if (reload_pend) begin
                    shifter     <= pend_word;
                    reload_pend <= 1'b0;
                    first_shift <= 1'b0;
                end else if (cpha && first_shift) begin
                    first_shift <= 1'b0;
                end else begin
                    shifter <= tx_shifted;
                end
            end

            if (state_q != IDLE && ss_rise) begin
                if (bit_cnt != '0 && !final_sample) abort <= 1'b1;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
        end
    end
endmodule
